// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with registered datapath controls.
// Every output is a flop, so each control is visible in the cycle of the state it belongs to.
module multicycle_ctrl #(
    parameter int unsigned IW     = 9,
    parameter int unsigned OPW    = 3,
    parameter int unsigned MEM_TO = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic [IW-1:0]  Instruction,
    input  logic           InstrValid,
    input  logic [1:0]     S,
    input  logic           MemAck,
    output logic           IRLoad,
    output logic           PCEn,
    output logic           BranchEn,
    output logic           MemToReg,
    output logic           MemWrite,
    output logic           MemRead,
    output logic           RegWrite,
    output logic           ALUSrc,
    output logic           Byte,
    output logic [OPW-1:0] ALUOp,
    output logic           Halted,
    output logic           MemErr
);
    localparam int unsigned CW = $clog2(MEM_TO + 1);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [1:0]     s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic           ir_load_q, ir_load_d, pc_en_q, pc_en_d, branch_en_q, branch_en_d;
    logic           mem_to_reg_q, mem_to_reg_d, mem_write_q, mem_write_d;
    logic           mem_read_q, mem_read_d, reg_write_q, reg_write_d;
    logic           alu_src_q, alu_src_d, byte_sel_q, byte_sel_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           halted_q, halted_d, mem_err_q, mem_err_d;

    logic [OPW-1:0] in_op;
    logic           cls_mem, cls_store, cls_branch, cls_halt, cls_nop;
    logic           unused_instr;

    assign in_op        = Instruction[IW-1:IW-OPW];
    assign unused_instr = ^Instruction[IW-OPW-1:0];
    assign cnt_inc      = cnt_q + CW'(1);

    // Instruction class comes from the captured opcode and flags, not the live inputs.
    assign cls_mem    = (op_q == OPW'(0));
    assign cls_store  = s_q[0];
    assign cls_branch = (op_q == OPW'(6));
    assign cls_halt   = (op_q == OPW'(7)) && (s_q == 2'b11);
    assign cls_nop    = (op_q == OPW'(7)) && (s_q != 2'b11);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        s_d          = s_q;
        cnt_d        = cnt_q;
        ir_load_d    = 1'b0;
        pc_en_d      = 1'b0;
        branch_en_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_d    = alu_src_q;
        byte_sel_d   = byte_sel_q;
        alu_op_d     = alu_op_q;
        halted_d     = halted_q;
        mem_err_d    = mem_err_q;

        unique case (state_q)
            StFetch: begin
                if (InstrValid) begin
                    ir_load_d  = 1'b1;
                    op_d       = in_op;
                    s_d        = S;
                    state_d    = StDecode;
                    // Decode alongside the capture so ALUOp is valid during DECODE.
                    alu_op_d   = in_op;
                    alu_src_d  = S[0];
                    byte_sel_d = 1'b0;
                    if (in_op == OPW'(0)) begin
                        alu_op_d   = OPW'(2);
                        alu_src_d  = 1'b1;
                        byte_sel_d = S[1];
                    end else if (in_op == OPW'(1)) begin
                        alu_op_d  = OPW'(1);
                        alu_src_d = 1'b1;
                    end else if (in_op == OPW'(6)) begin
                        alu_op_d  = OPW'(3);
                        alu_src_d = 1'b0;
                    end else if (in_op == OPW'(7)) begin
                        alu_op_d  = OPW'(0);
                        alu_src_d = 1'b0;
                    end else if ((in_op == OPW'(4)) && S[0]) begin
                        alu_op_d  = OPW'(6);
                        alu_src_d = 1'b1;
                    end
                end
            end
            StDecode: begin
                state_d     = StExec;
                branch_en_d = cls_branch;
                pc_en_d     = cls_branch || cls_nop;
            end
            StExec: begin
                if (cls_mem) begin
                    state_d     = StMem;
                    cnt_d       = '0;
                    mem_read_d  = !cls_store;
                    mem_write_d = cls_store;
                end else if (cls_branch || cls_nop) begin
                    state_d = StFetch;
                end else if (cls_halt) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    state_d     = StWb;
                    reg_write_d = 1'b1;
                    pc_en_d     = 1'b1;
                end
            end
            StMem: begin
                // Acknowledge is checked first so it wins over a same-cycle timeout.
                if (MemAck) begin
                    pc_en_d = 1'b1;
                    if (cls_store) begin
                        state_d = StFetch;
                    end else begin
                        state_d      = StWb;
                        reg_write_d  = 1'b1;
                        mem_to_reg_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(MEM_TO)) begin
                        state_d   = StHalt;
                        mem_err_d = 1'b1;
                        halted_d  = 1'b1;
                    end else begin
                        mem_read_d  = mem_read_q;
                        mem_write_d = mem_write_q;
                    end
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StFetch;
            op_q         <= '0;
            s_q          <= '0;
            cnt_q        <= '0;
            ir_load_q    <= 1'b0;
            pc_en_q      <= 1'b0;
            branch_en_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            byte_sel_q   <= 1'b0;
            alu_op_q     <= '0;
            halted_q     <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            ir_load_q    <= ir_load_d;
            pc_en_q      <= pc_en_d;
            branch_en_q  <= branch_en_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            reg_write_q  <= reg_write_d;
            alu_src_q    <= alu_src_d;
            byte_sel_q   <= byte_sel_d;
            alu_op_q     <= alu_op_d;
            halted_q     <= halted_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign IRLoad   = ir_load_q;
    assign PCEn     = pc_en_q;
    assign BranchEn = branch_en_q;
    assign MemToReg = mem_to_reg_q;
    assign MemWrite = mem_write_q;
    assign MemRead  = mem_read_q;
    assign RegWrite = reg_write_q;
    assign ALUSrc   = alu_src_q;
    assign Byte     = byte_sel_q;
    assign ALUOp    = alu_op_q;
    assign Halted   = halted_q;
    assign MemErr   = mem_err_q;

endmodule
